// File: rtl/noc_route_unit.sv
// noc_route_unit: pops flits from the input FIFO, XY-routes each head flit and forwards the packet to one of five ports; ROUTE_DROP_CNT_EN adds the drop_cnt counter
module noc_route_unit #(
    parameter int FLIT_W  = 16,
    parameter int COORD_W = 2,
    parameter int LOCAL_X = 0,
    parameter int LOCAL_Y = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_rd_en,
    input  logic [FLIT_W-1:0] fifo_data,
    output logic [4:0]        out_valid,
    input  logic [4:0]        out_ready,
    output logic [FLIT_W-1:0] out_flit,
    output logic              pkt_active,
`ifdef ROUTE_DROP_CNT_EN
    output logic [7:0]        drop_cnt,
`endif
    output logic [2:0]        cur_port
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
    state_t              state_q, state_d;
    logic [FLIT_W-1:0]   out_flit_q, out_flit_d;
    logic [4:0]          out_valid_q, out_valid_d;
    logic                pkt_active_q, pkt_active_d;
    logic [2:0]          cur_port_q, cur_port_d;
    logic [COORD_W-1:0]  dest_x, dest_y;
    logic [2:0]          route;
    logic                is_head, accept, pop;
    assign dest_x  = fifo_data[FLIT_W-3 -: COORD_W];
    assign dest_y  = fifo_data[FLIT_W-3-COORD_W -: COORD_W];
    assign is_head = fifo_data[FLIT_W-2];
    assign accept  = state_q == SEND && out_ready[cur_port_q];
    // Dimension-ordered route: resolve X first, then Y, else deliver locally
    always_comb begin
        route = dest_x > COORD_W'(LOCAL_X) ? 3'd0 :
                dest_x < COORD_W'(LOCAL_X) ? 3'd1 :
                dest_y > COORD_W'(LOCAL_Y) ? 3'd2 :
                dest_y < COORD_W'(LOCAL_Y) ? 3'd3 : 3'd4;
    end
    // Pop/load/send sequencing; the pop is issued in the cycle that sees a non-empty FIFO so the flit is on fifo_data during LOAD
    always_comb begin
        state_d      = state_q;
        out_flit_d   = out_flit_q;
        out_valid_d  = out_valid_q;
        pkt_active_d = pkt_active_q;
        cur_port_d   = cur_port_q;
        pop          = 1'b0;
        case (state_q)
            IDLE: begin
                pop     = !fifo_empty;
                state_d = fifo_empty ? IDLE : LOAD;
            end
            LOAD: begin
                out_flit_d = fifo_data;
                if (is_head) begin
                    cur_port_d   = route;
                    pkt_active_d = 1'b1;
                    out_valid_d  = 5'b1 << route;
                    state_d      = SEND;
                end else if (pkt_active_q) begin
                    out_valid_d = 5'b1 << cur_port_q;
                    state_d     = SEND;
                end else begin
                    pop     = !fifo_empty;
                    state_d = fifo_empty ? IDLE : LOAD;
                end
            end
            SEND: if (accept) begin
                out_valid_d  = '0;
                pkt_active_d = pkt_active_q & ~out_flit_q[FLIT_W-1];
                pop          = !fifo_empty;
                state_d      = fifo_empty ? IDLE : LOAD;
            end
            default: state_d = IDLE;
        endcase
    end
    // Reset has priority so no pop leaks out while it is held
    assign fifo_rd_en = pop & ~rst_n;
    // State and output registers; reset drops any held flit and route at once
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q      <= IDLE;
            out_flit_q   <= '0;
            out_valid_q  <= '0;
            pkt_active_q <= 1'b0;
            cur_port_q   <= '0;
        end else begin
            state_q      <= state_d;
            out_flit_q   <= out_flit_d;
            out_valid_q  <= out_valid_d;
            pkt_active_q <= pkt_active_d;
            cur_port_q   <= cur_port_d;
        end
    end
    assign out_flit   = out_flit_q;
    assign out_valid  = out_valid_q;
    assign pkt_active = pkt_active_q;
    assign cur_port   = cur_port_q;
`ifdef ROUTE_DROP_CNT_EN
    logic       drop;
    logic [7:0] drop_cnt_q, drop_cnt_d;
    // A drop is an orphan body/tail, or a head that cuts off an unfinished packet
    always_comb begin
        drop       = state_q == LOAD && (is_head ? pkt_active_q : !pkt_active_q);
        drop_cnt_d = drop && drop_cnt_q != 8'hFF ? drop_cnt_q + 8'd1 : drop_cnt_q;
    end
    // Saturating drop counter, cleared only by reset
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) drop_cnt_q <= '0;
        else drop_cnt_q <= drop_cnt_d;
    end
    assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_noc_route_unit.sv
// tb_noc_route_unit: scoreboard bench for noc_route_unit at LOCAL (0,0) and (1,1); drop_cnt checked when ROUTE_DROP_CNT_EN is defined
module tb_noc_route_unit;
    typedef struct {
        int          port;
        logic [15:0] flit;
    } exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;
    logic        fifo_rd_en0, fifo_rd_en1, fifo_empty0, fifo_empty1;
    logic [15:0] data0 = '0, data1 = '0, out_flit0, out_flit1;
    logic [4:0]  out_valid0, out_valid1, out_ready0, out_ready1;
    logic        pkt_active0, pkt_active1;
    logic [2:0]  cur_port0, cur_port1;
`ifdef ROUTE_DROP_CNT_EN
    logic [7:0]  drop_cnt0, drop_cnt1;
`endif
    logic [15:0] mem0 [64];
    logic [15:0] mem1 [64];
    logic [5:0]  wp0 = '0, rp0 = '0, wp1 = '0, rp1 = '0;
    assign fifo_empty0 = wp0 == rp0;
    assign fifo_empty1 = wp1 == rp1;
    always @(posedge clk) begin
        if (fifo_rd_en0) begin
            data0 <= mem0[rp0];
            rp0   <= rp0 + 6'd1;
        end
        if (fifo_rd_en1) begin
            data1 <= mem1[rp1];
            rp1   <= rp1 + 6'd1;
        end
    end
    noc_route_unit dut0 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty0), .fifo_rd_en(fifo_rd_en0),
        .fifo_data(data0), .out_valid(out_valid0), .out_ready(out_ready0),
        .out_flit(out_flit0), .pkt_active(pkt_active0),
`ifdef ROUTE_DROP_CNT_EN
        .drop_cnt(drop_cnt0),
`endif
        .cur_port(cur_port0)
    );
    noc_route_unit #(.LOCAL_X(1), .LOCAL_Y(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty1), .fifo_rd_en(fifo_rd_en1),
        .fifo_data(data1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_flit(out_flit1), .pkt_active(pkt_active1),
`ifdef ROUTE_DROP_CNT_EN
        .drop_cnt(drop_cnt1),
`endif
        .cur_port(cur_port1)
    );
    exp_t        exp0 [$];
    exp_t        exp1 [$];
    int          tests = 0, fails = 0, exp_drop = 0;
    logic [4:0]  pv0 = '0;
    logic [15:0] pf0 = '0;
    logic        pacc0 = 1'b0;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push0(input logic [15:0] f, input int port);
        exp_t e;
        mem0[wp0] = f;
        wp0 = wp0 + 6'd1;
        e.port = port;
        e.flit = f;
        if (port >= 0) exp0.push_back(e);
    endtask
    task automatic push1(input logic [15:0] f, input int port);
        exp_t e;
        mem1[wp1] = f;
        wp1 = wp1 + 6'd1;
        e.port = port;
        e.flit = f;
        exp1.push_back(e);
    endtask
    task automatic mon();
        exp_t e;
        if (rst_n) begin
            pv0 = '0;
        end else begin
            if (fifo_rd_en0) chk("pop_when_empty0", fifo_empty0, 0);
            if (fifo_rd_en1) chk("pop_when_empty1", fifo_empty1, 0);
            if (pv0 != 0 && !pacc0) begin
                chk("hold_valid0", out_valid0, pv0);
                chk("hold_flit0", out_flit0, pf0);
            end
            if (out_valid0 != 0) begin
                if (exp0.size() == 0) chk("unexpected_valid0", out_valid0, 0);
                else begin
                    e = exp0[0];
                    chk("port0", out_valid0, 32'd1 << e.port);
                    chk("flit0", out_flit0, e.flit);
                    chk("cur_port0", cur_port0, e.port);
                    if ((out_valid0 & out_ready0) != 0) void'(exp0.pop_front());
                end
            end
            if (out_valid1 != 0) begin
                if (exp1.size() == 0) chk("unexpected_valid1", out_valid1, 0);
                else begin
                    e = exp1[0];
                    chk("port1", out_valid1, 32'd1 << e.port);
                    chk("flit1", out_flit1, e.flit);
                    if ((out_valid1 & out_ready1) != 0) void'(exp1.pop_front());
                end
            end
            pv0   = out_valid0;
            pf0   = out_flit0;
            pacc0 = (out_valid0 & out_ready0) != 0;
        end
    endtask
    task automatic tick();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_valid0();
        for (int i = 0; i < 10 && out_valid0 == 0; i++) tick();
        chk("wait_valid0", out_valid0 != 0, 1);
    endtask
    task automatic drain();
        for (int i = 0; i < 60 && (exp0.size() != 0 || exp1.size() != 0 || !fifo_empty0 ||
             !fifo_empty1 || out_valid0 != 0 || out_valid1 != 0); i++) tick();
        chk("drain", exp0.size() + exp1.size(), 0);
    endtask
    task automatic chk_drop();
`ifdef ROUTE_DROP_CNT_EN
        chk("drop_cnt0", drop_cnt0, exp_drop);
`endif
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        out_ready0 = '1;
        out_ready1 = '1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", out_valid0, 0);
        chk("rst_rd_en", fifo_rd_en0, 0);
        chk("rst_flit", out_flit0, 0);
        chk("rst_pkt", pkt_active0, 0);
        chk("rst_port", cur_port0, 0);
        chk_drop();
        rst_n = 1'b0;
        tick();
        // single flit to (1,0): latency and release
        push0(16'hD0AB, 0);
        #1;
        chk("lat_pop", fifo_rd_en0, 1);
        chk("lat_v_idle", out_valid0, 0);
        tick();
        chk("lat_v_load", out_valid0, 0);
        chk("lat_rd_load", fifo_rd_en0, 0);
        tick();
        chk("lat_v_send", out_valid0, 5'b00001);
        chk("lat_flit", out_flit0, 16'hD0AB);
        chk("lat_pkt", pkt_active0, 1);
        tick();
        chk("single_pkt_clr", pkt_active0, 0);
        chk("single_v_clr", out_valid0, 0);
        // 4-flit packet to (2,0) with a stall on the first body flit
        out_ready0 = 5'b11110;
        push0(16'h6011, 0);
        push0(16'h0022, 0);
        push0(16'h0033, 0);
        push0(16'h8044, 0);
        wait_valid0();
        out_ready0 = 5'b11111;
        tick();
        out_ready0 = 5'b11110;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("stall_flit", out_flit0, 16'h0022);
            chk("stall_valid", out_valid0, 5'b00001);
            chk("stall_no_pop", fifo_rd_en0, 0);
            chk("stall_pkt", pkt_active0, 1);
            tick();
        end
        out_ready0 = 5'b11111;
        drain();
        chk("pkt_end", pkt_active0, 0);
        // orphan body with nothing behind it
        push0(16'h0055, -1);
        repeat (4) tick();
        chk("orphan_no_valid", out_valid0, 0);
        chk("orphan_pkt", pkt_active0, 0);
        exp_drop = 1;
        chk_drop();
        // orphan body immediately followed by a single flit to local
        push0(16'h0066, -1);
        push0(16'hC0AA, 4);
        drain();
        exp_drop = 2;
        chk_drop();
        // head to (1,0), head to (0,1) with missing tail, then tail
        push0(16'h5001, 0);
        push0(16'h4402, 2);
        push0(16'h8003, 2);
        drain();
        exp_drop = 3;
        chk_drop();
        chk("reroute_port", cur_port0, 2);
        chk("reroute_pkt", pkt_active0, 0);
        // XY decisions at LOCAL (1,1)
        push1(16'h5401, 4);
        push1(16'h4402, 1);
        push1(16'h5C03, 2);
        push1(16'h5004, 3);
        drain();
        chk("xy_pkt1", pkt_active1, 1);
        chk("xy_port1", cur_port1, 3);
        // reset while a flit is being presented
        out_ready0 = '0;
        push0(16'hD0CC, 0);
        wait_valid0();
        rst_n = 1'b1;
        #1;
        chk("arst_valid", out_valid0, 0);
        chk("arst_pkt", pkt_active0, 0);
        chk("arst_flit", out_flit0, 0);
        push0(16'hC0DD, -1);
        #1;
        chk("arst_no_pop", fifo_rd_en0, 0);
        exp_drop = 0;
        chk_drop();
        exp0.delete();
        push0(16'hC0DD, 4);
        wp0 = wp0 - 6'd1;
        tick();
        rst_n = 1'b0;
        out_ready0 = '1;
        drain();
        chk("post_rst_flit", out_flit0, 16'hC0DD);
        chk("post_rst_port", cur_port0, 4);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
